// File: rtl/busca_instrucao.sv
// Instruction fetch stage: holds the PC, drives the RAM read port, captures
// the registered RAM data one cycle later and buffers it in a small queue
// that the decoder drains over a valid/ready handshake. A redirect flushes
// every instruction and read that is in flight.
module busca_instrucao #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 2   // must be >= 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dado,
    input  logic                  desvio,
    input  logic [ADDR_WIDTH-1:0] desvio_addr,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] tag_q;
    logic                  in_flight_q;
    logic [DATA_WIDTH-1:0] fila_instr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] fila_pc_q    [DEPTH];
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [CNT_W:0]        occ;

    // Pointer increment that also wraps for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake and issue decisions for the coming edge.
    always_comb begin
        pop  = (count_q != '0) & instr_ready;
        push = in_flight_q & ~desvio;
        // Slots committed after this edge: queued + outstanding read - consumed.
        occ  = {1'b0, count_q} + {{CNT_W{1'b0}}, in_flight_q} - {{CNT_W{1'b0}}, pop};
        issue = ~desvio & (occ < DEPTH_OCC);
    end

    // PC, outstanding-read tracking and queue state; redirect wins over all.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= '0;
            tag_q       <= '0;
            in_flight_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fila_instr_q[i] <= '0;
                fila_pc_q[i]    <= '0;
            end
        end else if (desvio) begin
            // RAM data of this cycle is dropped along with the queue contents.
            pc_q        <= desvio_addr;
            in_flight_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            if (issue) begin
                in_flight_q <= 1'b1;
                tag_q       <= pc_q;
                pc_q        <= pc_q + ADDR_WIDTH'(1);
            end else begin
                // PC holds; the RAM harmlessly re-reads the same address.
                in_flight_q <= 1'b0;
            end
            if (push) begin
                fila_instr_q[tail_q] <= mem_dado;
                fila_pc_q[tail_q]    <= tag_q;
                tail_q               <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Head of the queue drives the decoder; zero while nothing is queued.
    always_comb begin
        mem_addr    = pc_q;
        instr_valid = (count_q != '0);
        instr       = instr_valid ? fila_instr_q[head_q] : '0;
        instr_pc    = instr_valid ? fila_pc_q[head_q] : '0;
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: a registered-read RAM preloaded with 0xA0+i,
// a queue-level model of the fetch stream, a per-cycle compare process and
// directed/randomized scenarios with literal expectations.
module tb_busca_instrucao;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 2;

    logic          clock;
    logic          reset_n;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dado;
    logic          desvio;
    logic [AW-1:0] desvio_addr;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] ram [16];

    // Model state: fetched PCs waiting for the decoder, the read issued at the
    // last edge (-1 if none), and the address currently presented to the RAM.
    int q[$];
    int pend;
    int npc;

    // PCs the DUT actually handed over (valid & ready), observed at negedge.
    int dlv[$];

    busca_instrucao #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .mem_addr(mem_addr),
        .mem_dado(mem_dado),
        .desvio(desvio),
        .desvio_addr(desvio_addr),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // RAM with registered read, read_clock tied to the fetch clock.
    always @(posedge clock) mem_dado <= ram[mem_addr];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_instr(input int pc);
        return (160 + pc) % 256;
    endfunction

    // Fetch-stream model: contiguous PCs from reset/redirect target, at most
    // DEPTH instructions committed (queued + outstanding), two-edge latency.
    always @(posedge clock or negedge reset_n) begin : model
        bit tk;
        int room;
        if (!reset_n) begin
            q.delete();
            pend = -1;
            npc  = 0;
        end else begin
            tk = (q.size() != 0) && instr_ready;
            if (desvio) begin
                q.delete();
                pend = -1;
                npc  = int'(desvio_addr);
            end else begin
                room = q.size() + ((pend >= 0) ? 1 : 0) - (tk ? 1 : 0);
                if (tk) void'(q.pop_front());
                if (pend >= 0) q.push_back(pend);
                if (room < DEPTH) begin
                    pend = npc;
                    npc  = (npc + 1) % 16;
                end else begin
                    pend = -1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus handshake recording.
    always @(negedge clock) begin
        if (reset_n) begin
            chk("mem_addr", int'(mem_addr), npc);
            chk("instr_valid", int'(instr_valid), (q.size() != 0) ? 1 : 0);
            if (q.size() != 0) begin
                chk("instr_pc", int'(instr_pc), q[0]);
                chk("instr", int'(instr), exp_instr(q[0]));
            end
            chk("occupancy_le_depth",
                ((int'(dut.count_q) + int'(dut.in_flight_q)) <= DEPTH) ? 1 : 0, 1);
            if (instr_valid && instr_ready) dlv.push_back(int'(instr_pc));
        end
    end

    // Advance one edge; inputs change and literal checks happen 2 after it.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = DW'(8'hA0 + i);
        reset_n     = 1'b0;
        desvio      = 1'b0;
        desvio_addr = '0;
        instr_ready = 1'b0;
        repeat (2) cyc();

        // Sustained fetch from reset with ready held high, across the PC wrap.
        instr_ready = 1'b1;
        reset_n     = 1'b1;
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_valid", int'(instr_valid), 0);
        chk("rst_instr", int'(instr), 0);
        chk("rst_instr_pc", int'(instr_pc), 0);
        cyc();
        chk("c1_valid", int'(instr_valid), 0);
        cyc();
        chk("c2_instr", int'(instr), 8'hA0);
        chk("c2_pc", int'(instr_pc), 0);
        for (int k = 3; k < 20; k++) begin
            cyc();
            if (k == 17) begin
                chk("c17_instr", int'(instr), 8'hAF);
                chk("c17_pc", int'(instr_pc), 15);
            end
            if (k == 18) begin
                chk("wrap_instr", int'(instr), 8'hA0);
                chk("wrap_pc", int'(instr_pc), 0);
            end
        end

        // Stall from cycle 0, then release.
        instr_ready = 1'b0;
        do_reset();
        repeat (6) cyc();
        chk("stall_valid", int'(instr_valid), 1);
        chk("stall_instr", int'(instr), 8'hA0);
        chk("stall_mem_addr", int'(mem_addr), 2);
        instr_ready = 1'b1;
        dlv.delete();
        cyc();
        chk("rel_instr1", int'(instr), 8'hA1);
        cyc();
        chk("rel_instr2", int'(instr), 8'hA2);
        cyc();
        chk("rel_count", dlv.size(), 3);
        for (int i = 0; i < dlv.size(); i++) chk("rel_seq", dlv[i], i);

        // Redirect with a full queue.
        instr_ready = 1'b0;
        do_reset();
        repeat (4) cyc();
        chk("full_valid", int'(instr_valid), 1);
        desvio      = 1'b1;
        desvio_addr = AW'(9);
        dlv.delete();
        cyc();
        desvio = 1'b0;
        chk("rd_e_valid", int'(instr_valid), 0);
        chk("rd_e_addr", int'(mem_addr), 9);
        cyc();
        chk("rd_e1_valid", int'(instr_valid), 0);
        cyc();
        chk("rd_e2_instr", int'(instr), 8'hA9);
        chk("rd_e2_pc", int'(instr_pc), 9);
        instr_ready = 1'b1;
        cyc();
        chk("rd_e3_instr", int'(instr), 8'hAA);
        cyc();
        chk("rd_dlv_count", dlv.size(), 2);
        if (dlv.size() == 2) begin
            chk("rd_dlv0", dlv[0], 9);
            chk("rd_dlv1", dlv[1], 10);
        end

        // Redirect coincident with the pop of pc 3.
        instr_ready = 1'b1;
        do_reset();
        repeat (5) cyc();
        chk("co_head_pc", int'(instr_pc), 3);
        desvio      = 1'b1;
        desvio_addr = AW'(12);
        dlv.delete();
        cyc();
        desvio = 1'b0;
        cyc();
        cyc();
        chk("co_target_pc", int'(instr_pc), 12);
        cyc();
        chk("co_dlv_count", dlv.size(), 2);
        if (dlv.size() == 2) begin
            chk("co_dlv0", dlv[0], 3);
            chk("co_dlv1", dlv[1], 12);
        end

        // Random backpressure: delivered stream must be contiguous mod 16.
        do_reset();
        dlv.delete();
        repeat (200) begin
            instr_ready = $urandom_range(0, 1) != 0;
            cyc();
        end
        chk("rnd_progress", (dlv.size() >= 40) ? 1 : 0, 1);
        for (int i = 0; i < dlv.size(); i++) chk("rnd_seq", dlv[i], i % 16);

        // Asynchronous reset mid-cycle with the queue full.
        instr_ready = 1'b0;
        do_reset();
        repeat (4) cyc();
        chk("pre_rst_valid", int'(instr_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("async_valid", int'(instr_valid), 0);
        chk("async_instr", int'(instr), 0);
        chk("async_pc", int'(instr_pc), 0);
        chk("async_mem_addr", int'(mem_addr), 0);
        reset_n     = 1'b1;
        instr_ready = 1'b1;
        cyc();
        cyc();
        chk("restart_instr", int'(instr), 8'hA0);
        chk("restart_pc", int'(instr_pc), 0);
        cyc();
        chk("restart_instr1", int'(instr), 8'hA1);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
